// File: rtl/i2c_bit_ctrl.sv
// I2C master bit engine: executes START/WRITE/READ/STOP one at a time, aligned to
// the edges of the free-running scl_gen square wave; drives open-drain enables.
module i2c_bit_ctrl #(
  parameter int unsigned HOLD_CYC = 10,
  parameter int unsigned MID_CYC  = 1250
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       scl_gen,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_nack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_rx,
  output logic       err,
  output logic       busy,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       scl_oe
);

  typedef enum logic [2:0] {IDLE, START_A, START_B, BIT, STOP_A, STOP_B} state_e;
  typedef enum logic [1:0] {CMD_START = 2'd0, CMD_WRITE = 2'd1,
                            CMD_READ  = 2'd2, CMD_STOP  = 2'd3} cmd_e;

  localparam logic [11:0] HOLD_LAST = 12'(HOLD_CYC - 1);
  localparam logic [11:0] MID_LAST  = 12'(MID_CYC - 1);

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic        scl_q;
  logic [11:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [7:0]  sh_q, sh_d;
  logic        nack_q, nack_d;
  logic [3:0]  bit_q, bit_d;
  logic        samp_q, samp_d;
  logic        sda_q, sda_d;
  logic        scl_oe_q, scl_oe_d;
  logic        busy_q, busy_d;
  logic        rsp_q, rsp_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        rdy_q, rdy_d;

  logic rise, fall, hold_hit, mid_hit, accept;

  assign rise     = scl_gen & ~scl_q;
  assign fall     = ~scl_gen & scl_q;
  // An edge in the same cycle as a threshold wins: the action is skipped.
  assign hold_hit = ~rise & ~fall & (cnt_q == HOLD_LAST);
  assign mid_hit  = ~rise & ~fall & (cnt_q == MID_LAST);
  assign accept   = cmd_valid & rdy_q;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    pend_d   = pend_q;
    sh_d     = sh_q;
    nack_d   = nack_q;
    bit_d    = bit_q;
    samp_d   = samp_q;
    sda_d    = sda_q;
    busy_d   = busy_q;
    rsp_d    = 1'b0;
    err_d    = err_q;
    ack_d    = ack_q;
    rdat_d   = rdat_q;
    scl_oe_d = 1'b0;
    rdy_d    = 1'b0;
    cnt_d    = (rise || fall) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 12'd1);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_e'(cmd) != CMD_START && !busy_q) begin
            rsp_d = 1'b1;
            err_d = 1'b1;
          end else begin
            pend_d = 1'b1;
            cmd_d  = cmd_e'(cmd);
            sh_d   = wr_data;
            nack_d = rd_nack;
          end
        end else if (pend_q) begin
          // A fresh START aligns to a rise; everything else aligns to a fall.
          if (cmd_q == CMD_START && !busy_q) begin
            if (rise) begin
              state_d = START_A;
              pend_d  = 1'b0;
            end
          end else if (fall) begin
            pend_d = 1'b0;
            bit_d  = '0;
            unique case (cmd_q)
              CMD_START: state_d = START_B;
              CMD_STOP:  state_d = STOP_A;
              default:   state_d = BIT;
            endcase
          end
        end
      end
      START_A: begin
        if (fall) begin
          state_d = IDLE;
          rsp_d   = 1'b1;
          err_d   = 1'b0;
        end else if (mid_hit) begin
          sda_d  = 1'b1;
          busy_d = 1'b1;
        end
      end
      START_B: begin
        if (rise) state_d = START_A;
        else if (hold_hit) sda_d = 1'b0;
      end
      BIT: begin
        if (fall) begin
          if (bit_q == 4'd8) begin
            state_d = IDLE;
            rsp_d   = 1'b1;
            err_d   = 1'b0;
            if (cmd_q == CMD_READ) rdat_d = sh_q;
            else                   ack_d  = samp_q;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else if (rise) begin
          if (bit_q == 4'd8) samp_d = sda_in;
          else               sh_d   = {sh_q[6:0], sda_in};
        end else if (hold_hit) begin
          if (cmd_q == CMD_WRITE) sda_d = (bit_q < 4'd8) ? ~sh_q[7] : 1'b0;
          else                    sda_d = (bit_q < 4'd8) ? 1'b0 : ~nack_q;
        end
      end
      STOP_A: begin
        if (rise) state_d = STOP_B;
        else if (hold_hit) sda_d = 1'b1;
      end
      STOP_B: begin
        if (mid_hit) begin
          sda_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
          rsp_d   = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // SCL held low while owning the bus between commands; follows scl_gen while clocking.
    if (!busy_d || state_d == STOP_B)            scl_oe_d = 1'b0;
    else if (state_d == IDLE || state_d == STOP_A) scl_oe_d = 1'b1;
    else                                          scl_oe_d = ~scl_gen;

    rdy_d = (state_d == IDLE) && !pend_d && !rsp_d;
  end

  always_ff @(posedge CLK) begin
    scl_q <= scl_gen;
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_START;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      sh_q     <= '0;
      nack_q   <= 1'b0;
      bit_q    <= '0;
      samp_q   <= 1'b0;
      sda_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      rsp_q    <= 1'b0;
      err_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      sh_q     <= sh_d;
      nack_q   <= nack_d;
      bit_q    <= bit_d;
      samp_q   <= samp_d;
      sda_q    <= sda_d;
      scl_oe_q <= scl_oe_d;
      busy_q   <= busy_d;
      rsp_q    <= rsp_d;
      err_q    <= err_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      rdy_q    <= rdy_d;
    end
  end

  assign cmd_ready = rdy_q;
  assign rsp_valid = rsp_q;
  assign rd_data   = rdat_q;
  assign ack_rx    = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign sda_oe    = sda_q;
  assign scl_oe    = scl_oe_q;

endmodule
